fft_frame_sequencer: RTL and testbench
======================================

Name: fft_frame_sequencer

Overview:
- Frame-level scheduler for the 64-point, 16-bit (32-bit complex) FFT datapath.
- Counts a 64-sample input stream into eight 8-sample segments and steers the input buffer write selects.
- Sequences stage-1 compute, corner-buffer load, stage-2 compute and a 64-cycle output drain; raises Data_Out while results are read.
- Sits between the top-level stream ports and the input buffer, corner buffer and output serializer.

Parameters:
N_PT, 64, samples per frame; must equal SEG_LEN*SEG_LEN.
SEG_LEN, 8, samples per segment (radix of each 8-point stage).
IDX_W, 6, width of sample index; log2(N_PT).
CALC_LAT, 4, cycles allowed per 8-point stage incl. inter-dimensional multiply; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
Data_Start  in  1  marks sample 0 of a frame; samples follow on 63 consecutive cycles.
Mode  in  1  0 = FFT, 1 = IFFT; sampled only on an accepted Data_Start.
in_wr_en  out  1  input buffer write enable for the current sample.
in_seg_sel  out  3  target segment, = load_idx[5:3].
in_pos_sel  out  3  position in segment, = load_idx[2:0].
calc_start  out  1  one-cycle pulse: stage-1 inputs complete.
cb_load  out  1  one-cycle pulse: corner buffer captures stage-1 results.
out_rd_idx  out  6  natural-order output index k during drain.
out_addr  out  6  digit-reversed read address {k[2:0],k[5:3]}.
Data_Out  out  1  output sample valid.
mode_lat  out  1  Mode latched for the frame in flight.
busy  out  1  high whenever state != IDLE.
frame_err  out  1  sticky: Data_Start arrived while not acceptable.

Behaviour:
- States: IDLE, LOAD, STAGE1, STAGE2, DRAIN.
- Counters:
  - load_idx (6b): wraps 63->0.
  - calc_cnt (4b).
  - drain_idx (6b): wraps 63->0.
- IDLE with Data_Start=1:
  - sample 0 is written in that same cycle: in_wr_en=1 combinationally, load_idx=0.
  - mode_lat <= Mode.
  - next state LOAD with load_idx=1.
- LOAD: in_wr_en=1 each cycle; load_idx increments. On load_idx==63, the next state is STAGE1 with calc_cnt=0.
- Frame with Data_Start at cycle t0:
  - sample 63 is written at t0+63.
  - calc_start=1 at t0+64 (first STAGE1 cycle only).
- STAGE1 lasts CALC_LAT cycles; cb_load=1 on its last cycle. STAGE2 then lasts CALC_LAT cycles.
- DRAIN lasts 64 cycles:
  - Data_Out=1 throughout.
  - out_rd_idx = drain_idx, running 0..63.
  - out_addr = digit-reversed drain_idx.
  - First Data_Out at t0+64+2*CALC_LAT; last at t0+127+2*CALC_LAT.
  - Then IDLE.
- Outside LOAD/DRAIN: in_wr_en=0, Data_Out=0, out_rd_idx=0, out_addr=0.
- Data_Start when not acceptable:
  - ignored; no restart, no Mode latch.
  - frame_err <= 1, cleared only by rst.
- Data_Start during the LOAD cycle with load_idx==63 is also an error; the frame still completes.
- Reset (any state, mid-frame included), at the next edge:
  - state=IDLE, all counters=0.
  - all registered outputs 0: mode_lat, frame_err, busy, calc_start, cb_load, Data_Out, out_rd_idx, out_addr.
  - in_wr_en=0 while rst is high, even if Data_Start=1.
- All outputs except the IDLE-cycle in_wr_en, in_seg_sel and in_pos_sel are registered or decoded from registered state only.

Optional Feature:
FFT_SEQ_OVERLAP_EN
- Defined:
  - Data_Start is also accepted during DRAIN; the new frame loads concurrently through an independent load_idx, and mode_lat_next captures Mode.
  - When DRAIN ends, the FSM enters LOAD, continuing load_idx without a gap, and mode_lat <= mode_lat_next.
  - A Data_Start in the final DRAIN cycle enters LOAD with load_idx=1.
  - Data_Start in LOAD, STAGE1 or STAGE2 is still a frame_err.
  - A Data_Start during DRAIN while a next frame is already pending is also a frame_err.
- Undefined: Data_Start in any non-IDLE state is ignored and sets frame_err.

Test Plan:
- Reset, then Data_Start at t0=10 with Mode=1, CALC_LAT=4 -> in_wr_en 10..73; in_seg_sel=3 and in_pos_sel=5 at cycle 39; calc_start at 74; cb_load at 77; Data_Out 82..145; mode_lat=1; busy low at 146.
- Drain address check -> out_rd_idx=1 gives out_addr=8; 9 gives 9; 13 gives 41; 63 gives 63.
- Data_Start at cycle 40 of the above frame (overlap undefined) -> frame_err=1 from 41; the frame completes unchanged; the next Data_Start at 150 is accepted.
- rst asserted at cycle 80 (STAGE2) -> all outputs 0 and busy=0 from 81; Data_Start at 85 is accepted as a fresh frame.
- FFT_SEQ_OVERLAP_EN: second Data_Start at cycle 120 (DRAIN) -> Data_Out 82..145 contiguous; in_wr_en 120..183; calc_start at 184; frame_err stays 0.
- CALC_LAT=1 -> calc_start and cb_load on the same cycle t0+64; Data_Out starts at t0+66.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// Frame scheduler for the 64-point two-stage FFT: input load counting, stage timing and output drain.
// Optional feature macro FFT_SEQ_OVERLAP_EN: accept the next frame's input while the current one drains.
module fft_frame_sequencer #(
   parameter int N_PT     = 64,
   parameter int SEG_LEN  = 8,
   parameter int IDX_W    = 6,
   parameter int CALC_LAT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               Data_Start,
   input  logic               Mode,
   output logic               in_wr_en,
   output logic [IDX_W/2-1:0] in_seg_sel,
   output logic [IDX_W/2-1:0] in_pos_sel,
   output logic               calc_start,
   output logic               cb_load,
   output logic [IDX_W-1:0]   out_rd_idx,
   output logic [IDX_W-1:0]   out_addr,
   output logic               Data_Out,
   output logic               mode_lat,
   output logic               busy,
   output logic               frame_err
);

   localparam int               DIG_W     = $clog2(SEG_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_PT - 1);
   localparam logic [3:0]       CALC_LAST = 4'(CALC_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_STAGE1,
      S_STAGE2,
      S_DRAIN
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] load_idx_q, load_idx_d;
   logic [3:0]       calc_cnt_q, calc_cnt_d;
   logic [IDX_W-1:0] drain_idx_q, drain_idx_d;
   logic             mode_lat_q, mode_lat_d;
   logic             frame_err_q, frame_err_d;
   logic             wr_en_c;
`ifdef FFT_SEQ_OVERLAP_EN
   logic             pend_q, pend_d;
   logic             mode_nxt_q, mode_nxt_d;
   logic             take_c;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         load_idx_q  <= '0;
         calc_cnt_q  <= '0;
         drain_idx_q <= '0;
         mode_lat_q  <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef FFT_SEQ_OVERLAP_EN
         pend_q      <= 1'b0;
         mode_nxt_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         load_idx_q  <= load_idx_d;
         calc_cnt_q  <= calc_cnt_d;
         drain_idx_q <= drain_idx_d;
         mode_lat_q  <= mode_lat_d;
         frame_err_q <= frame_err_d;
`ifdef FFT_SEQ_OVERLAP_EN
         pend_q      <= pend_d;
         mode_nxt_q  <= mode_nxt_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      load_idx_d  = load_idx_q;
      calc_cnt_d  = calc_cnt_q;
      drain_idx_d = drain_idx_q;
      mode_lat_d  = mode_lat_q;
      frame_err_d = frame_err_q;
      wr_en_c     = 1'b0;
`ifdef FFT_SEQ_OVERLAP_EN
      pend_d      = pend_q;
      mode_nxt_d  = mode_nxt_q;
      take_c      = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            // Sample 0 is written in the Data_Start cycle itself.
            if (Data_Start) begin
               wr_en_c    = 1'b1;
               mode_lat_d = Mode;
               load_idx_d = IDX_W'(1);
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            wr_en_c     = 1'b1;
            load_idx_d  = load_idx_q + 1'b1;
            frame_err_d = frame_err_q | Data_Start;
            if (load_idx_q == LAST_IDX) begin
               state_d    = S_STAGE1;
               calc_cnt_d = '0;
            end
         end
         S_STAGE1: begin
            frame_err_d = frame_err_q | Data_Start;
            if (calc_cnt_q == CALC_LAST) begin
               state_d    = S_STAGE2;
               calc_cnt_d = '0;
            end else begin
               calc_cnt_d = calc_cnt_q + 1'b1;
            end
         end
         S_STAGE2: begin
            frame_err_d = frame_err_q | Data_Start;
            if (calc_cnt_q == CALC_LAST) begin
               state_d     = S_DRAIN;
               calc_cnt_d  = '0;
               drain_idx_d = '0;
            end else begin
               calc_cnt_d = calc_cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            drain_idx_d = drain_idx_q + 1'b1;
`ifdef FFT_SEQ_OVERLAP_EN
            take_c      = Data_Start & ~pend_q;
            frame_err_d = frame_err_q | (Data_Start & pend_q);
            if (pend_q | take_c) begin
               wr_en_c    = 1'b1;
               load_idx_d = load_idx_q + 1'b1;
            end
            if (take_c) begin
               pend_d     = 1'b1;
               mode_nxt_d = Mode;
            end
`else
            frame_err_d = frame_err_q | Data_Start;
`endif
            if (drain_idx_q == LAST_IDX) begin
               state_d = S_IDLE;
`ifdef FFT_SEQ_OVERLAP_EN
               pend_d = 1'b0;
               // A frame started on drain cycle 0 has all 64 samples in by now.
               if (pend_q | take_c) begin
                  mode_lat_d = pend_q ? mode_nxt_q : Mode;
                  calc_cnt_d = '0;
                  state_d    = (load_idx_q == LAST_IDX) ? S_STAGE1 : S_LOAD;
               end
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_wr_en   = wr_en_c & ~rst;
   assign in_seg_sel = load_idx_q[2*DIG_W-1:DIG_W];
   assign in_pos_sel = load_idx_q[DIG_W-1:0];
   assign busy       = (state_q != S_IDLE);
   assign calc_start = (state_q == S_STAGE1) && (calc_cnt_q == 4'd0);
   assign cb_load    = (state_q == S_STAGE1) && (calc_cnt_q == CALC_LAST);
   assign Data_Out   = (state_q == S_DRAIN);
   assign out_rd_idx = Data_Out ? drain_idx_q : '0;
   assign out_addr   = Data_Out ? {drain_idx_q[DIG_W-1:0], drain_idx_q[2*DIG_W-1:DIG_W]} : '0;
   assign mode_lat   = mode_lat_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench: two sequencer instances (CALC_LAT 4 and 1) share random Data_Start/Mode/rst stimulus;
// expected events come from a frame-timing model built on each frame's start cycle.
`timescale 1ns/1ps
module tb_fft_frame_sequencer;

   localparam int NI  = 2;
   localparam int INF = 32'h3fffffff;
`ifdef FFT_SEQ_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   typedef struct packed {
      int cyc;
      int a;
      int b;
      int c;
   } ev_t;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       ds   = 1'b0;
   logic       mode = 1'b0;
   logic       wr_en  [NI];
   logic [2:0] seg    [NI];
   logic [2:0] pos    [NI];
   logic       cs     [NI];
   logic       cb     [NI];
   logic [5:0] rd_idx [NI];
   logic [5:0] addr   [NI];
   logic       dout   [NI];
   logic       mlat   [NI];
   logic       bsy    [NI];
   logic       ferr   [NI];

   int  cyc    = 0;
   int  checks = 0;
   int  errors = 0;
   bit  chk_en = 1'b0;

   // Event kinds: 0 in_wr_en, 1 calc_start, 2 cb_load, 3 Data_Out
   ev_t evq [NI][4][$];
   int  busy_from [NI];
   int  busy_until[NI];
   int  last_d0   [NI];
   int  err_from  [NI];
   int  err_until [NI];
   int  mode_pend_cyc[NI];
   bit  mode_pend_val[NI];
   bit  mode_cur     [NI];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int cl_of(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic string kname(input int k);
      case (k)
         0: return "in_wr_en";
         1: return "calc_start";
         2: return "cb_load";
         default: return "Data_Out";
      endcase
   endfunction

   task automatic check_inst(input int i);
      int  c;
      bit  flag[4];
      int  aa[4];
      int  bb[4];
      int  cc[4];
      ev_t e;
      bit  exp_b;
      c = cyc;
      flag[0] = wr_en[i]; aa[0] = int'(seg[i]);    bb[0] = int'(pos[i]);  cc[0] = 0;
      flag[1] = cs[i];    aa[1] = 0;               bb[1] = 0;             cc[1] = 0;
      flag[2] = cb[i];    aa[2] = 0;               bb[2] = 0;             cc[2] = 0;
      flag[3] = dout[i];  aa[3] = int'(rd_idx[i]); bb[3] = int'(addr[i]); cc[3] = int'(mlat[i]);
      if (c >= mode_pend_cyc[i]) begin
         mode_cur[i]      = mode_pend_val[i];
         mode_pend_cyc[i] = INF;
      end
      for (int k = 0; k < 4; k++) begin
         while (evq[i][k].size() > 0 && evq[i][k][0].cyc < c) begin
            e = evq[i][k].pop_front();
            checks++; errors++;
            $display("FAIL inst%0d %s missing: none at cycle %0d, required a=%0d b=%0d", i, kname(k), e.cyc, e.a, e.b);
         end
         if (flag[k]) begin
            checks++;
            if (evq[i][k].size() > 0 && evq[i][k][0].cyc == c) begin
               e = evq[i][k].pop_front();
               if (e.a != aa[k] || e.b != bb[k] || e.c != cc[k]) begin
                  errors++;
                  $display("FAIL inst%0d %s cycle %0d got a=%0d b=%0d c=%0d required a=%0d b=%0d c=%0d",
                           i, kname(k), c, aa[k], bb[k], cc[k], e.a, e.b, e.c);
               end
            end else begin
               errors++;
               $display("FAIL inst%0d %s unexpected at cycle %0d (a=%0d b=%0d), required low", i, kname(k), c, aa[k], bb[k]);
            end
         end
      end
      exp_b = (c >= busy_from[i]) && (c <= busy_until[i]);
      checks++;
      if (bsy[i] !== exp_b) begin
         errors++;
         $display("FAIL inst%0d busy cycle %0d got %0b required %0b", i, c, bsy[i], exp_b);
      end
      exp_b = (c >= err_from[i]) && (c <= err_until[i]);
      checks++;
      if (ferr[i] !== exp_b) begin
         errors++;
         $display("FAIL inst%0d frame_err cycle %0d got %0b required %0b", i, c, ferr[i], exp_b);
      end
      checks++;
      if (mlat[i] !== mode_cur[i]) begin
         errors++;
         $display("FAIL inst%0d mode_lat cycle %0d got %0b required %0b", i, c, mlat[i], mode_cur[i]);
      end
      if (!dout[i]) begin
         checks++;
         if (rd_idx[i] !== 6'd0 || addr[i] !== 6'd0) begin
            errors++;
            $display("FAIL inst%0d idle_out cycle %0d got rd=%0d addr=%0d required 0/0", i, c, rd_idx[i], addr[i]);
         end
      end
   endtask

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      fft_frame_sequencer #(
         .N_PT    (64),
         .SEG_LEN (8),
         .IDX_W   (6),
         .CALC_LAT((gi == 0) ? 4 : 1)
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .Data_Start(ds),
         .Mode      (mode),
         .in_wr_en  (wr_en[gi]),
         .in_seg_sel(seg[gi]),
         .in_pos_sel(pos[gi]),
         .calc_start(cs[gi]),
         .cb_load   (cb[gi]),
         .out_rd_idx(rd_idx[gi]),
         .out_addr  (addr[gi]),
         .Data_Out  (dout[gi]),
         .mode_lat  (mlat[gi]),
         .busy      (bsy[gi]),
         .frame_err (ferr[gi])
      );
      always @(negedge clk) if (chk_en) check_inst(gi);
   end

   // Reference model: a frame accepted at t has fixed event times relative to t.
   task automatic model_ds(input int i, input int t, input bit m);
      int  cl;
      ev_t e;
      cl = cl_of(i);
      if (t > busy_until[i] || (OVL && t >= last_d0[i])) begin
         if (t > busy_until[i]) begin
            busy_from[i]     = t + 1;
            mode_pend_cyc[i] = t + 1;
         end else begin
            mode_pend_cyc[i] = busy_until[i] + 1;
         end
         mode_pend_val[i] = m;
         busy_until[i]    = t + 127 + 2*cl;
         last_d0[i]       = t + 64 + 2*cl;
         for (int k = 0; k < 64; k++) begin
            e = '{cyc: t + k, a: k / 8, b: k % 8, c: 0};
            evq[i][0].push_back(e);
         end
         e = '{cyc: t + 64, a: 0, b: 0, c: 0};
         evq[i][1].push_back(e);
         e = '{cyc: t + 63 + cl, a: 0, b: 0, c: 0};
         evq[i][2].push_back(e);
         for (int k = 0; k < 64; k++) begin
            e = '{cyc: t + 64 + 2*cl + k, a: k, b: (k % 8) * 8 + k / 8, c: int'(m)};
            evq[i][3].push_back(e);
         end
         $display("frame inst%0d start=%0d mode=%0b drain=%0d..%0d", i, t, m, last_d0[i], busy_until[i]);
      end else begin
         if (!(err_from[i] <= t + 1 && err_until[i] >= t + 1)) begin
            err_from[i]  = t + 1;
            err_until[i] = INF;
         end
         $display("reject inst%0d Data_Start at %0d", i, t);
      end
   endtask

   task automatic model_reset(input int i, input int r);
      ev_t keep[$];
      for (int k = 0; k < 4; k++) begin
         keep.delete();
         for (int j = 0; j < evq[i][k].size(); j++)
            if (evq[i][k][j].cyc < r || (k != 0 && evq[i][k][j].cyc == r))
               keep.push_back(evq[i][k][j]);
         evq[i][k] = keep;
      end
      if (busy_until[i] > r) busy_until[i] = r;
      if (err_until[i] > r) err_until[i] = r;
      if (mode_pend_cyc[i] <= r) mode_cur[i] = mode_pend_val[i];
      mode_pend_cyc[i] = r + 1;
      mode_pend_val[i] = 1'b0;
   endtask

   task automatic step(input bit d, input bit m);
      @(posedge clk);
      #1;
      rst  = 1'b0;
      ds   = d;
      mode = m;
      if (d) for (int i = 0; i < NI; i++) model_ds(i, cyc, m);
   endtask

   task automatic do_rst();
      @(posedge clk);
      #1;
      rst = 1'b1;
      ds  = 1'b0;
      $display("reset at cycle %0d", cyc);
      for (int i = 0; i < NI; i++) model_reset(i, cyc);
   endtask

   task automatic run_to(input int target);
      while (cyc + 1 < target) step(1'b0, 1'($urandom_range(0, 1)));
   endtask

   function automatic int max_busy();
      return (busy_until[0] > busy_until[1]) ? busy_until[0] : busy_until[1];
   endfunction

   int t0;

   initial begin
      for (int i = 0; i < NI; i++) begin
         busy_from[i]     = 0;
         busy_until[i]    = -1;
         last_d0[i]       = INF;
         err_from[i]      = INF;
         err_until[i]     = INF;
         mode_pend_cyc[i] = INF;
         mode_pend_val[i] = 1'b0;
         mode_cur[i]      = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;

      // Basic frame with stray Data_Starts in LOAD (mid and last sample)
      run_to(cyc + 8);
      step(1'b1, 1'b1);
      t0 = cyc;
      run_to(t0 + 30);
      step(1'b1, 1'b0);
      run_to(t0 + 63);
      step(1'b1, 1'b0);
      run_to(max_busy() + 4);

      // Second frame; Data_Start during drain, then at the last drain cycle
      step(1'b1, 1'b0);
      t0 = cyc;
      run_to(t0 + 110);
      step(1'b1, 1'b1);
      run_to(max_busy() + 3);
      step(1'b1, 1'b1);
      t0 = cyc;
      run_to(busy_until[0]);
      step(1'b1, 1'b0);
      run_to(max_busy() + 3);

      // Reset during STAGE2, then a fresh frame
      step(1'b1, 1'b1);
      t0 = cyc;
      run_to(t0 + 70);
      do_rst();
      run_to(t0 + 75);
      step(1'b1, 1'b0);
      run_to(max_busy() + 3);

      // Randomized traffic
      for (int n = 0; n < 5000; n++) begin
         int r;
         r = $urandom_range(0, 999);
         if (r < 2) do_rst();
         else if (r < 25) step(1'b1, 1'($urandom_range(0, 1)));
         else step(1'b0, 1'($urandom_range(0, 1)));
      end
      run_to(max_busy() + 5);
      step(1'b0, 1'b0);

      for (int i = 0; i < NI; i++)
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (evq[i][k].size() != 0) begin
               errors++;
               $display("FAIL inst%0d %s leftover: %0d pending events, required 0", i, kname(k), evq[i][k].size());
            end
         end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
